// File: rtl/i2c_target.sv
// I2C target: oversamples SCL/SDA on clk, decodes START/STOP, 7-bit address,
// R/W, data and ACK. Drives SDA open-drain through sda_oe (1 = pull low).
module i2c_target #(
  parameter logic [6:0] ADDR = 7'b1100110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK
  } state_t;

  logic scl_s1_q, scl_s2_q, scl_prev_q;
  logic sda_s1_q, sda_s2_q, sda_prev_q;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_load_q, tx_load_d;
  logic       busy_q, busy_d;

  logic scl_rise, scl_fall, start_det, stop_det;

  // Two-flop synchronizers plus one edge-history flop per bus line; idle bus is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1_q <= 1'b1; scl_s2_q <= 1'b1; scl_prev_q <= 1'b1;
      sda_s1_q <= 1'b1; sda_s2_q <= 1'b1; sda_prev_q <= 1'b1;
    end else begin
      scl_s1_q <= scl;      scl_s2_q <= scl_s1_q; scl_prev_q <= scl_s2_q;
      sda_s1_q <= sda_in;   sda_s2_q <= sda_s1_q; sda_prev_q <= sda_s2_q;
    end
  end

  // Bus events; START/STOP require SCL high on both compared samples.
  always_comb begin
    scl_rise  = scl_s2_q & ~scl_prev_q;
    scl_fall  = ~scl_s2_q & scl_prev_q;
    start_det = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
    stop_det  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;
  end

  // Protocol state, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_load_q  <= tx_load_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic. cnt==8 marks "byte done, 9th clock pending"; the 9th
  // rising edge wraps it to 0 so the following falling edge closes the ACK slot.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    busy_d     = busy_q;
    if (start_det) begin
      state_d  = S_ADDR;
      sda_oe_d = 1'b0;
      cnt_d    = 4'd0;
    end else if (stop_det) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      cnt_d    = 4'd0;
    end else begin
      case (state_q)
        S_ADDR: if (scl_rise) begin
          shift_d = {shift_q[6:0], sda_s2_q};
          if (cnt_q == 4'd7) begin
            // Address 0 (general call) is never acknowledged.
            if (shift_d[7:1] == ADDR && shift_d[7:1] != 7'd0) begin
              state_d = S_ADDR_ACK;
              busy_d  = 1'b1;
              rw_d    = sda_s2_q;
              cnt_d   = 4'd8;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              cnt_d   = 4'd0;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_ADDR_ACK, S_WRITE_ACK: begin
          if (scl_rise) begin
            cnt_d = 4'd0;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b1;
            end else if (state_q == S_WRITE_ACK || !rw_q) begin
              sda_oe_d = 1'b0;
              state_d  = S_WRITE;
            end else begin
              tx_load_d = 1'b1;
              shift_d   = tx_data;
              sda_oe_d  = ~tx_data[7];
              state_d   = S_READ;
            end
          end
        end
        S_WRITE: if (scl_rise) begin
          shift_d = {shift_q[6:0], sda_s2_q};
          if (cnt_q == 4'd7) begin
            rx_data_d  = shift_d;
            rx_valid_d = 1'b1;
            state_d    = S_WRITE_ACK;
            cnt_d      = 4'd8;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_READ: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = S_READ_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        S_READ_ACK: begin
          if (scl_rise) begin
            cnt_d = 4'd0;
            if (sda_s2_q) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end else if (scl_fall && cnt_q == 4'd0) begin
            tx_load_d = 1'b1;
            shift_d   = tx_data;
            sda_oe_d  = ~tx_data[7];
            state_d   = S_READ;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_load  = tx_load_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-level bus master task set drives directed and
// random transactions; expectations come from transaction-level rules.
module tb_i2c_target;

  localparam logic [6:0] MY_ADDR = 7'h66;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load;
  logic       busy;

  // Wired-AND open-drain bus.
  assign sda_in = m_sda & ~sda_oe;

  i2c_target #(.ADDR(MY_ADDR)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_in), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_load(tx_load), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Event monitor.
  int         rx_cnt, txl_cnt;
  bit         oe_seen, busy_low, busy_hi;
  logic [7:0] rxq[$];

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      rxq.push_back(rx_data);
    end
    if (tx_load) txl_cnt++;
    if (sda_oe) oe_seen = 1'b1;
    if (!busy) busy_low = 1'b1;
    if (busy) busy_hi = 1'b1;
  end

  task automatic clear_mon();
    rx_cnt = 0; txl_cnt = 0; oe_seen = 0; busy_low = 0; busy_hi = 0;
    rxq.delete();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic qtr();
    repeat (5) @(negedge clk);
  endtask

  task automatic bstart();
    m_sda = 1'b1; qtr(); scl = 1'b1; qtr(); m_sda = 1'b0; qtr(); scl = 1'b0; qtr();
  endtask

  task automatic bstop();
    m_sda = 1'b0; qtr(); scl = 1'b1; qtr(); m_sda = 1'b1; qtr(); qtr();
  endtask

  task automatic bbit(input logic b, output logic r);
    m_sda = b; qtr(); scl = 1'b1; qtr(); r = sda_in; qtr(); scl = 1'b0; qtr();
  endtask

  // Master writes a byte; ack=1 when the target pulled SDA low on the 9th clock.
  task automatic wbyte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bbit(d[i], r);
    bbit(1'b1, r);
    ack = ~r;
  endtask

  // Master reads a byte; nxt is presented on tx_data before the 9th clock.
  task automatic rbyte(input logic mack, input logic [7:0] nxt, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bbit(1'b1, r);
      d[i] = r;
    end
    tx_data = nxt;
    bbit(~mack, r);
  endtask

  initial begin
    logic       ack, r;
    logic [7:0] d, d1, d2, ta, tb2;
    logic [6:0] a;
    logic       rw, hit;
    int         n;
    logic [7:0] expq[$];
    logic [7:0] tq[4];

    clear_mon();
    repeat (4) @(negedge clk);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_load", tx_load, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    qtr();

    // Single write 0x66+W, 0xA5, STOP.
    clear_mon();
    bstart();
    wbyte({MY_ADDR, 1'b0}, ack); chk("w1_addr_ack", ack, 1);
    chk("w1_busy", busy, 1);
    wbyte(8'hA5, ack); chk("w1_data_ack", ack, 1);
    bstop();
    chk("w1_busy_after_stop", busy, 0);
    chk("w1_rx_cnt", rx_cnt, 1);
    chk("w1_rx_val", rxq.size() > 0 ? rxq[0] : 8'hxx, 8'hA5);
    chk("w1_rx_data", rx_data, 8'hA5);

    // Foreign address 0x33.
    clear_mon();
    bstart();
    wbyte({7'h33, 1'b0}, ack); chk("na_addr_ack", ack, 0);
    wbyte(8'hFF, ack); chk("na_data_ack", ack, 0);
    bstop();
    chk("na_oe_seen", oe_seen, 0);
    chk("na_rx_cnt", rx_cnt, 0);
    chk("na_busy_hi", busy_hi, 0);

    // General call address is not acknowledged.
    clear_mon();
    bstart();
    wbyte(8'h00, ack); chk("gc_addr_ack", ack, 0);
    bstop();
    chk("gc_busy_hi", busy_hi, 0);

    // Read 0x66+R, tx 0x3C, master NACK.
    clear_mon();
    tx_data = 8'h3C;
    bstart();
    wbyte({MY_ADDR, 1'b1}, ack); chk("r1_addr_ack", ack, 1);
    rbyte(1'b0, 8'h00, d);
    chk("r1_data", d, 8'h3C);
    chk("r1_tx_load_cnt", txl_cnt, 1);
    chk("r1_sda_oe_after_nack", sda_oe, 0);
    chk("r1_busy_after_nack", busy, 0);
    bstop();

    // Two-byte write 0x12, 0x34.
    clear_mon();
    bstart();
    wbyte({MY_ADDR, 1'b0}, ack); chk("w2_addr_ack", ack, 1);
    wbyte(8'h12, ack); chk("w2_ack0", ack, 1);
    wbyte(8'h34, ack); chk("w2_ack1", ack, 1);
    bstop();
    chk("w2_rx_cnt", rx_cnt, 2);
    chk("w2_rx0", rxq.size() > 0 ? rxq[0] : 8'hxx, 8'h12);
    chk("w2_rx1", rxq.size() > 1 ? rxq[1] : 8'hxx, 8'h34);

    // Partial write, repeated START, then two-byte read.
    clear_mon();
    ta  = 8'($urandom);
    tb2 = 8'($urandom);
    tx_data = ta;
    bstart();
    wbyte({MY_ADDR, 1'b0}, ack); chk("rs_addr_ack", ack, 1);
    busy_low = 0;
    bbit(1'b1, r); bbit(1'b0, r); bbit(1'b1, r); bbit(1'b1, r);
    bstart();
    wbyte({MY_ADDR, 1'b1}, ack); chk("rs_raddr_ack", ack, 1);
    rbyte(1'b1, tb2, d1);
    chk("rs_busy_held", busy_low, 0);
    chk("rs_busy_now", busy, 1);
    rbyte(1'b0, 8'h00, d2);
    bstop();
    chk("rs_d1", d1, ta);
    chk("rs_d2", d2, tb2);
    chk("rs_tx_load_cnt", txl_cnt, 2);
    chk("rs_rx_cnt", rx_cnt, 0);

    // Reset pulse mid data byte.
    clear_mon();
    bstart();
    wbyte({MY_ADDR, 1'b0}, ack); chk("rr_addr_ack", ack, 1);
    bbit(1'b1, r); bbit(1'b0, r); bbit(1'b1, r); bbit(1'b0, r);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rr_sda_oe", sda_oe, 0);
    chk("rr_rx_data", rx_data, 0);
    chk("rr_rx_valid", rx_valid, 0);
    chk("rr_tx_load", tx_load, 0);
    chk("rr_busy", busy, 0);
    bbit(1'b0, r); bbit(1'b1, r); bbit(1'b0, r); bbit(1'b1, r);
    bbit(1'b1, r); chk("rr_no_ack", r, 1);
    bstop();
    chk("rr_rx_cnt", rx_cnt, 0);
    clear_mon();
    d = 8'($urandom);
    bstart();
    wbyte({MY_ADDR, 1'b0}, ack); chk("rr_new_addr_ack", ack, 1);
    wbyte(d, ack); chk("rr_new_data_ack", ack, 1);
    bstop();
    chk("rr_new_rx", rxq.size() > 0 ? rxq[0] : 8'hxx, d);

    // Random transactions against the transaction-level model.
    for (int t = 0; t < 10; t++) begin
      a   = ($urandom % 2) ? MY_ADDR : 7'($urandom_range(0, 127));
      rw  = 1'($urandom);
      n   = $urandom_range(1, 3);
      hit = (a == MY_ADDR) && (a != 7'd0);
      clear_mon();
      expq.delete();
      for (int i = 0; i < 4; i++) tq[i] = 8'($urandom);
      tx_data = tq[0];
      bstart();
      wbyte({a, rw}, ack); chk("rnd_addr_ack", ack, 32'(hit));
      if (!rw) begin
        for (int i = 0; i < n; i++) begin
          d = 8'($urandom);
          wbyte(d, ack); chk("rnd_w_ack", ack, 32'(hit));
          if (hit) expq.push_back(d);
        end
        bstop();
        chk("rnd_rx_cnt", rx_cnt, expq.size());
        for (int i = 0; i < expq.size(); i++)
          chk("rnd_rx_val", rxq.size() > i ? rxq[i] : 8'hxx, expq[i]);
      end else begin
        for (int i = 0; i < n; i++) begin
          rbyte(i < n - 1, tq[i+1], d);
          chk("rnd_r_data", d, hit ? tq[i] : 8'hFF);
        end
        bstop();
        chk("rnd_tx_load_cnt", txl_cnt, hit ? n : 0);
        chk("rnd_rx_cnt_rd", rx_cnt, 0);
      end
      chk("rnd_busy_end", busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
